// File: rtl/data_memory_bank_if.sv
// Purpose : request/response bundle between the load/store path and data_memory_bank.
// Latency : n/a (wires only); read data returns RD_LAT cycles after acceptance.
// Backpressure: master may only count a request as taken on a cycle where ready is high.
// Ports   : master drives en/wen/be/addr/data_in; slave drives ready/data_out/rvalid/init_done.
interface data_memory_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  en;
    logic                  wen;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rvalid;
    logic                  init_done;

    modport master (
        output en, wen, be, addr, data_in,
        input  ready, data_out, rvalid, init_done
    );

    modport slave (
        input  en, wen, be, addr, data_in,
        output ready, data_out, rvalid, init_done
    );
endinterface

// File: rtl/data_memory_bank.sv
// Purpose : single-port data memory with per-byte write strobes and a self-clearing init sweep.
// Latency : reads return RD_LAT (1 or 2) cycles after acceptance; writes complete on the accept edge.
// Backpressure: ready is low for DEPTH cycles after every reset while memory is cleared, then stays high.
// Ports   : clk, rst_n (sync, active low); bus = slave side of data_memory_bank_if.
module data_memory_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    data_memory_bank_if.slave   bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("data_memory_bank: RD_LAT must be 1 or 2");
        end
        if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
            $error("data_memory_bank: DATA_WIDTH must be a multiple of 8");
        end
    endgenerate

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  clr_we;
    logic                  run;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_dat;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rvalid_q;

    // State register and clear pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clr_we) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

    // Next state: the sweep leaves INIT on the edge that clears the last word.
    always_comb begin
        state_d = state_q;
        clr_we  = 1'b0;
        run     = 1'b0;
        case (state_q)
            INIT: begin
                clr_we = 1'b1;
                if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                run = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // en is only honoured once the clear sweep has finished.
    assign wr_acc = run & bus.en & bus.wen;
    assign rd_acc = run & bus.en & ~bus.wen;

    // Storage is left out of reset so it maps onto a RAM; the INIT sweep clears it instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                mem[ptr_q] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.be[i]) begin
                        mem[bus.addr][8*i +: 8] <= bus.data_in[8*i +: 8];
                    end
                end
            end
        end
    end

    assign rd_dat = mem[bus.addr];

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s1_dat_q;
            logic                  s1_vld_q;

            // Extra register stage; s1 data is captured at the accept edge so later
            // writes to the same word cannot alter a read already in the pipe.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_vld_q <= 1'b0;
                    s1_dat_q <= '0;
                    rvalid_q <= 1'b0;
                    dout_q   <= '0;
                end else begin
                    s1_vld_q <= rd_acc;
                    if (rd_acc) begin
                        s1_dat_q <= rd_dat;
                    end
                    rvalid_q <= s1_vld_q;
                    if (s1_vld_q) begin
                        dout_q <= s1_dat_q;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rvalid_q <= 1'b0;
                    dout_q   <= '0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= rd_dat;
                    end
                end
            end
        end
    endgenerate

    // init_done is sticky by construction: RUN is only left through reset.
    assign bus.ready     = run;
    assign bus.init_done = run;
    assign bus.rvalid    = rvalid_q;
    assign bus.data_out  = dout_q;
endmodule

// File: tb/tb_data_memory_bank.sv
// Bench for data_memory_bank: drives an RD_LAT=1 and an RD_LAT=2 instance with identical
// stimulus; a word-array model predicts read data and the cycle each rvalid is due,
// and a negedge monitor pops and compares every response.
module tb_data_memory_bank;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    data_memory_bank_if bus1 ();
    data_memory_bank_if bus2 ();

    data_memory_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LAT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    data_memory_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LAT(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t        sb_q [2][$];
    logic [31:0] ref_mem [256];
    logic [31:0] last_dat [2];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic        rst_seen = 1'b1;

    logic [1:0]  rv;
    logic [31:0] dout [2];

    assign rv[0]   = bus1.rvalid;
    assign rv[1]   = bus2.rvalid;
    assign dout[0] = bus1.data_out;
    assign dout[1] = bus2.data_out;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !rst_n;
    end

    // Monitor: every rvalid must match the oldest expectation, on exactly its due cycle;
    // between pulses data_out must hold the last returned value.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_seen) begin
                sb_q[i].delete();
                last_dat[i] = '0;
                n_checks++;
                if (rv[i] !== 1'b0 || dout[i] !== 32'h0) begin
                    n_errors++;
                    $display("FAIL reset_out lat%0d: rvalid=%b data_out=%h, required rvalid=0 data_out=00000000",
                             i + 1, rv[i], dout[i]);
                end
            end else if (rv[i] === 1'b1) begin
                n_checks++;
                if (sb_q[i].size() == 0) begin
                    n_errors++;
                    $display("FAIL rvalid_unexpected lat%0d cyc %0d: rvalid=1 data_out=%h, required no rvalid",
                             i + 1, cyc, dout[i]);
                end else begin
                    exp_t e;
                    e = sb_q[i].pop_front();
                    if (dout[i] !== e.dat || cyc != e.due) begin
                        n_errors++;
                        $display("FAIL read_data lat%0d: data_out=%h at cyc %0d, required %h at cyc %0d",
                                 i + 1, dout[i], cyc, e.dat, e.due);
                    end
                    last_dat[i] = e.dat;
                end
            end else begin
                if (sb_q[i].size() != 0 && sb_q[i][0].due <= cyc) begin
                    exp_t e;
                    e = sb_q[i].pop_front();
                    n_checks++;
                    n_errors++;
                    $display("FAIL rvalid_missing lat%0d: rvalid=0 at cyc %0d, required rvalid=1 data %h",
                             i + 1, cyc, e.dat);
                end
                n_checks++;
                if (dout[i] !== last_dat[i]) begin
                    n_errors++;
                    $display("FAIL hold lat%0d cyc %0d: data_out=%h, required %h",
                             i + 1, cyc, dout[i], last_dat[i]);
                end
            end
        end
    end

    task automatic set_bus(input logic e, input logic w, input logic [3:0] b,
                           input logic [7:0] a, input logic [31:0] d);
        bus1.en = e;  bus1.wen = w;  bus1.be = b;  bus1.addr = a;  bus1.data_in = d;
        bus2.en = e;  bus2.wen = w;  bus2.be = b;  bus2.addr = a;  bus2.data_in = d;
    endtask

    // Drive one cycle from a negedge; the model applies the request if it will be accepted.
    task automatic step(input logic e, input logic w, input logic [3:0] b,
                        input logic [7:0] a, input logic [31:0] d);
        set_bus(e, w, b, a, d);
        if (e && bus1.ready === 1'b1) begin
            if (w) begin
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    exp_t x;
                    x.dat = ref_mem[a];
                    x.due = cyc + i + 1;
                    sb_q[i].push_back(x);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic check_ctrl(input string name, input logic want);
        n_checks++;
        if (bus1.ready !== want || bus1.init_done !== want ||
            bus2.ready !== want || bus2.init_done !== want) begin
            n_errors++;
            $display("FAIL %s cyc %0d: ready=%b%b init_done=%b%b, required all %b",
                     name, cyc, bus1.ready, bus2.ready, bus1.init_done, bus2.init_done, want);
        end
    endtask

    // Hold reset for 'edges' rising edges, then follow the 256-edge clear sweep.
    task automatic do_reset(input int edges);
        set_bus(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        rst_n = 1'b0;
        repeat (edges) @(negedge clk);
        check_ctrl("reset_ctrl", 1'b0);
        for (int k = 0; k < 256; k++) ref_mem[k] = '0;
        rst_n = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            check_ctrl("init_ctrl", (k == 256) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        set_bus(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        last_dat[0] = '0;
        last_dat[1] = '0;
        @(negedge clk);
        do_reset(2);

        // Cleared memory, top address.
        step(1'b1, 1'b0, 4'h0, 8'hFF, 32'h0);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);

        // Byte-strobe merge.
        step(1'b1, 1'b1, 4'b1111, 8'h10, 32'hDEADBEEF);
        step(1'b1, 1'b1, 4'b0101, 8'h10, 32'h11223344);
        step(1'b1, 1'b0, 4'h0,    8'h10, 32'h0);

        // Streaming reads of preloaded words.
        step(1'b1, 1'b1, 4'hF, 8'h01, 32'd1);
        step(1'b1, 1'b1, 4'hF, 8'h02, 32'd2);
        step(1'b1, 1'b1, 4'hF, 8'h03, 32'd3);
        step(1'b1, 1'b0, 4'h0, 8'h01, 32'h0);
        step(1'b1, 1'b0, 4'h0, 8'h02, 32'h0);
        step(1'b1, 1'b0, 4'h0, 8'h03, 32'h0);

        // Zero strobes change nothing.
        step(1'b1, 1'b1, 4'h0, 8'h20, 32'hA5A5A5A5);
        step(1'b1, 1'b0, 4'h0, 8'h20, 32'h0);

        // Single read then idle: data_out must hold.
        step(1'b1, 1'b1, 4'hF, 8'h30, 32'd7);
        step(1'b1, 1'b0, 4'h0, 8'h30, 32'h0);
        repeat (5) step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);

        // Write followed by a read in flight through the pipe.
        step(1'b1, 1'b0, 4'h0, 8'h30, 32'h0);
        step(1'b1, 1'b1, 4'hF, 8'h30, 32'h12345678);
        step(1'b1, 1'b0, 4'h0, 8'h30, 32'h0);

        // Randomised traffic, biased to a small address window for collisions.
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), a, $urandom);
        end
        repeat (4) step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);

        // Reset while a read is in flight.
        step(1'b1, 1'b1, 4'hF, 8'h40, 32'hCAFEF00D);
        step(1'b1, 1'b0, 4'h0, 8'h40, 32'h0);
        do_reset(1);
        step(1'b1, 1'b0, 4'h0, 8'h40, 32'h0);
        step(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);

        // Drain outstanding reads with a bounded wait.
        for (int n = 0; n < 10; n++) begin
            if (sb_q[0].size() == 0 && sb_q[1].size() == 0) break;
            step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        end
        n_checks++;
        if (sb_q[0].size() != 0 || sb_q[1].size() != 0) begin
            n_errors++;
            $display("FAIL drain: outstanding reads %0d/%0d, required 0/0", sb_q[0].size(), sb_q[1].size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
